hazard_controller: RTL

//  Pipeline sequencer for the 5-stage rv32imc core: detects RAW hazards at DE, drives

---
 rtl/hazard_controller_pkg.sv | 30 +++
 rtl/hazard_controller_forward_select.sv | 39 +++
 rtl/hazard_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// sequencer states, forwarding-source encoding and the RAW match rule.
package hazard_controller_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_BUBBLE  = 2'd1,
        HZ_MEMWAIT = 2'd2
    } HazardStateType;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } ForwardSelType;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic regMatch(
        input logic                  useRs,
        input logic [REG_ADDR_W-1:0] rsAddr,
        input logic                  writeEn,
        input logic [REG_ADDR_W-1:0] rdAddr
    );
        return useRs && writeEn && (rdAddr == rsAddr) && (rsAddr != '0);
    endfunction

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Per-operand forwarding source selection: youngest producer wins (EX > MEM > WB),
// except that a load sitting in EX has no result yet and cannot be forwarded.
module forward_select
    import hazard_controller_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rsAddr,
    input  logic                  i_useRs,
    input  logic [REG_ADDR_W-1:0] i_rdAddrEX,
    input  logic                  i_rdWriteEnEX,
    input  logic [REG_ADDR_W-1:0] i_rdAddrMEM,
    input  logic                  i_rdWriteEnMEM,
    input  logic [REG_ADDR_W-1:0] i_rdAddrWB,
    input  logic                  i_rdWriteEnWB,
    input  logic                  i_blockEX,
    output logic                  o_matchEX,
    output ForwardSelType         o_sel
);

    logic w_matchEX;
    logic w_matchMEM;
    logic w_matchWB;

    assign w_matchEX  = regMatch(i_useRs, i_rsAddr, i_rdWriteEnEX,  i_rdAddrEX);
    assign w_matchMEM = regMatch(i_useRs, i_rsAddr, i_rdWriteEnMEM, i_rdAddrMEM);
    assign w_matchWB  = regMatch(i_useRs, i_rsAddr, i_rdWriteEnWB,  i_rdAddrWB);
    assign o_matchEX  = w_matchEX;

    always_comb begin
        o_sel = FWD_RF;
        if (w_matchEX && !i_blockEX) begin
            o_sel = FWD_EX;
        end else if (w_matchMEM) begin
            o_sel = FWD_MEM;
        end else if (w_matchWB) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: forwarding selects, load-use bubbles, data-memory freeze
// and branch flushes, plus saturating stall/redirect performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic [REG_ADDR_W-1:0] i_rs1AddrDE,
    input  logic [REG_ADDR_W-1:0] i_rs2AddrDE,
    input  logic                  i_useRs1DE,
    input  logic                  i_useRs2DE,
    input  logic [REG_ADDR_W-1:0] i_rdAddrEX,
    input  logic                  i_rdWriteEnEX,
    input  logic                  i_loadSignalEX,
    input  logic [REG_ADDR_W-1:0] i_rdAddrMEM,
    input  logic                  i_rdWriteEnMEM,
    input  logic [REG_ADDR_W-1:0] i_rdAddrWB,
    input  logic                  i_rdWriteEnWB,
    input  logic                  i_branchTakenEX,
    input  logic                  i_memReqMEM,
    input  logic                  i_memReadyMEM,
    output logic                  o_stallFE,
    output logic                  o_stallDE,
    output logic                  o_stallEX,
    output logic                  o_stallMEM,
    output logic                  o_flushDE,
    output logic                  o_flushEX,
    output logic [1:0]            o_forwardRs1DE,
    output logic [1:0]            o_forwardRs2DE,
    output logic [CNT_WIDTH-1:0]  o_stallCount,
    output logic [CNT_WIDTH-1:0]  o_flushCount
);

    HazardStateType r_state;
    HazardStateType w_nextState;

    ForwardSelType  w_fwdSel1;
    ForwardSelType  w_fwdSel2;
    logic           w_matchEX1;
    logic           w_matchEX2;
    logic           w_memWait;
    logic           w_loadUse;
    logic           w_redirect;

    logic [CNT_WIDTH-1:0] r_stallCount;
    logic [CNT_WIDTH-1:0] r_flushCount;

    forward_select u_fwdRs1 (
        .i_rsAddr       (i_rs1AddrDE),
        .i_useRs        (i_useRs1DE),
        .i_rdAddrEX     (i_rdAddrEX),
        .i_rdWriteEnEX  (i_rdWriteEnEX),
        .i_rdAddrMEM    (i_rdAddrMEM),
        .i_rdWriteEnMEM (i_rdWriteEnMEM),
        .i_rdAddrWB     (i_rdAddrWB),
        .i_rdWriteEnWB  (i_rdWriteEnWB),
        .i_blockEX      (i_loadSignalEX),
        .o_matchEX      (w_matchEX1),
        .o_sel          (w_fwdSel1)
    );

    forward_select u_fwdRs2 (
        .i_rsAddr       (i_rs2AddrDE),
        .i_useRs        (i_useRs2DE),
        .i_rdAddrEX     (i_rdAddrEX),
        .i_rdWriteEnEX  (i_rdWriteEnEX),
        .i_rdAddrMEM    (i_rdAddrMEM),
        .i_rdWriteEnMEM (i_rdWriteEnMEM),
        .i_rdAddrWB     (i_rdAddrWB),
        .i_rdWriteEnWB  (i_rdWriteEnWB),
        .i_blockEX      (i_loadSignalEX),
        .o_matchEX      (w_matchEX2),
        .o_sel          (w_fwdSel2)
    );

    // In BUBBLE the load has moved to MEM, so the same dependency must not stall again
    assign w_memWait  = i_memReqMEM && !i_memReadyMEM;
    assign w_redirect = !w_memWait && i_branchTakenEX;
    assign w_loadUse  = !w_memWait && !i_branchTakenEX && (r_state != HZ_BUBBLE) &&
                        i_loadSignalEX && (w_matchEX1 || w_matchEX2);

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = HZ_RUN;
        if (w_memWait) begin
            w_nextState = HZ_MEMWAIT;
        end else if (w_loadUse) begin
            w_nextState = HZ_BUBBLE;
        end
    end

    // Reset gates the combinational controls so the pipe is released even mid-freeze
    always_comb begin
        o_stallFE      = 1'b0;
        o_stallDE      = 1'b0;
        o_stallEX      = 1'b0;
        o_stallMEM     = 1'b0;
        o_flushDE      = 1'b0;
        o_flushEX      = 1'b0;
        o_forwardRs1DE = FWD_RF;
        o_forwardRs2DE = FWD_RF;
        if (i_arstn) begin
            o_forwardRs1DE = w_fwdSel1;
            o_forwardRs2DE = w_fwdSel2;
            if (w_memWait) begin
                o_stallFE  = 1'b1;
                o_stallDE  = 1'b1;
                o_stallEX  = 1'b1;
                o_stallMEM = 1'b1;
            end else if (w_redirect) begin
                o_flushDE  = 1'b1;
                o_flushEX  = 1'b1;
            end else if (w_loadUse) begin
                o_stallFE  = 1'b1;
                o_stallDE  = 1'b1;
                o_flushEX  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if ((w_memWait || w_loadUse) && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_WIDTH'(1);
            end
            if (w_redirect && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + CNT_WIDTH'(1);
            end
        end
    end

    assign o_stallCount = r_stallCount;
    assign o_flushCount = r_flushCount;

endmodule
